uart_rx_os16: RTL and testbench

- Robust UART receiver for the serial link: 8N1 frames, LSB first, 16x oversampling.
- Resolves the start edge, samples each bit at mid-bit, checks the stop bit, and presents each byte on a valid/ready handshake.
- Sits between the async `rx` pin and the byte consumer.
- Complements `uarttx`: same `clk_freq`/`baud_rate` parameters, same line format.

---
 rtl/uart_rx_os16.sv | 180 ++++++++++++++++++
 tb/tb_uart_rx_os16.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os16.sv
// 8N1 UART receiver with 16x oversampling: start-edge resolve, mid-bit sampling, stop-bit check.
// Latency: rx_valid rises 1 clk after the stop-bit sample (about 9.5 bit times after start edge + 2-3 clk sync).
// Backpressure: one-byte holding register; a good frame arriving while rx_valid is held is dropped with an overrun pulse.
module uart_rx_os16 #(
    parameter int clk_freq  = 10000000,
    parameter int baud_rate = 9600,
    parameter int os_rate   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int DIV = clk_freq / (baud_rate * os_rate);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            rx_meta;
    logic            rxs;
    logic            rxs_d;
    logic [DW-1:0]   div_cnt;
    logic            tick;
    logic [3:0]      tc;
    logic [2:0]      bc;
    logic [7:0]      shreg;
    logic            fall;
    logic            start_det;
    logic            tc_clr;
    logic            shift_en;
    logic            stop_smp;
    logic            good;
    logic            load;
    logic            ovr;
    logic            ferr;

    assign fall      = rxs_d & ~rxs;
    assign start_det = (state == S_IDLE) && fall;
    assign tick      = (div_cnt == DIV_MAX);
    assign busy      = (state != S_IDLE);

    // Two-flop synchroniser on the async line plus one delayed copy for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_d   <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
            rxs_d   <= rxs;
        end
    end

    // Oversample tick divider, re-phased to the start edge so samples land mid-bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (start_det || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and per-cycle strobes for the datapath.
    always_comb begin
        state_nxt = state;
        tc_clr    = 1'b0;
        shift_en  = 1'b0;
        stop_smp  = 1'b0;
        case (state)
            S_IDLE: begin
                if (fall) begin
                    tc_clr    = 1'b1;
                    state_nxt = S_START;
                end
            end
            S_START: begin
                if (tick && tc == 4'd7) begin
                    if (!rxs) begin
                        tc_clr    = 1'b1;
                        state_nxt = S_DATA;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (tick && tc == 4'd15) begin
                    shift_en = 1'b1;
                    if (bc == 3'd7) begin
                        state_nxt = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (tick && tc == 4'd15) begin
                    stop_smp  = 1'b1;
                    state_nxt = rxs ? S_IDLE : S_BREAK;
                end
            end
            S_BREAK: begin
                if (rxs) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // A load in the same clk as an accept wins, so it is not an overrun.
    assign good = stop_smp && rxs;
    assign load = good && (!rx_valid || rx_ready);
    assign ovr  = good && rx_valid && !rx_ready;
    assign ferr = stop_smp && !rxs;

    // Tick-within-bit counter, bit counter and LSB-first shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tc    <= '0;
            bc    <= '0;
            shreg <= '0;
        end else begin
            if (tc_clr) begin
                tc <= '0;
            end else if (tick) begin
                tc <= tc + 4'd1;
            end
            if (shift_en) begin
                bc    <= bc + 3'd1;
                shreg <= {rxs, shreg[7:1]};
            end
        end
    end

    // Output holding register, valid/ready handshake and error pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= ferr;
            overrun   <= ovr;
            if (load) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_os16.sv
// Directed bench for uart_rx_os16: drives serial frames on rx and checks the byte handshake and error pulses.
// Clock scaled to 2 MHz so DIV=13 and one bit is 208 clk; the run stays short.
// Inputs change 1 ns after posedge; a negedge monitor tallies pulses and accepted bytes.
module tb_uart_rx_os16;

    localparam int BIT = 208;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    int         fe_cnt   = 0;
    int         ov_cnt   = 0;
    int         rise_cnt = 0;
    logic       vld_d    = 1'b0;
    logic [7:0] acc_q[$];

    uart_rx_os16 #(
        .clk_freq (2000000),
        .baud_rate(9600),
        .os_rate  (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Tally pulses, valid rising edges and accepted bytes away from the active edge.
    always @(negedge clk) begin
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
        if (rx_valid && !vld_d) rise_cnt++;
        if (rx_valid && rx_ready) acc_q.push_back(rx_data);
        vld_d = rx_valid;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] qat(input int i);
        return (i < acc_q.size()) ? {24'h0, acc_q[i]} : 32'hFFFF_FFFF;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic hold(input logic v, input int n);
        rx = v;
        idle(n);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        hold(1'b0, BIT);
        for (int i = 0; i < 8; i++) hold(d[i], BIT);
        hold(stop, BIT);
    endtask

    initial begin
        int f0, r0, o0, q0;
        logic [7:0] part;
        rst      = 1'b1;
        rx       = 1'b1;
        rx_ready = 1'b0;
        idle(5);
        rst = 1'b0;
        idle(2);

        // Reset state.
        chk("rst_data", rx_data, 0);
        chk("rst_valid", rx_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_ovr", overrun, 0);

        // Single byte with consumer stalled, then a one-clk accept.
        f0 = fe_cnt;
        send_byte(8'hA5, 1'b1);
        chk("single_valid", rx_valid, 1);
        chk("single_data", rx_data, 32'hA5);
        chk("single_ferr", fe_cnt - f0, 0);
        chk("single_busy", busy, 0);
        rx_ready = 1'b1;
        idle(1);
        rx_ready = 1'b0;
        chk("accept_valid", rx_valid, 0);
        chk("accept_data_hold", rx_data, 32'hA5);

        // Back-to-back frames, no idle gap, consumer always ready.
        q0 = acc_q.size();
        r0 = rise_cnt;
        rx_ready = 1'b1;
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h3C, 1'b1);
        idle(BIT);
        chk("b2b_count", acc_q.size() - q0, 3);
        chk("b2b_byte0", qat(q0), 32'h00);
        chk("b2b_byte1", qat(q0 + 1), 32'hFF);
        chk("b2b_byte2", qat(q0 + 2), 32'h3C);
        chk("b2b_rises", rise_cnt - r0, 3);

        // Short low glitch is rejected at the mid start-bit check.
        f0 = fe_cnt;
        r0 = rise_cnt;
        hold(1'b0, 40);
        hold(1'b1, BIT);
        chk("glitch_busy", busy, 0);
        chk("glitch_rises", rise_cnt - r0, 0);
        chk("glitch_ferr", fe_cnt - f0, 0);
        q0 = acc_q.size();
        send_byte(8'h55, 1'b1);
        idle(BIT / 2);
        chk("glitch_next_byte", qat(q0), 32'h55);
        chk("glitch_next_rises", rise_cnt - r0, 1);

        // Bad stop bit followed by a held-low line: one frame_err only.
        f0 = fe_cnt;
        r0 = rise_cnt;
        send_byte(8'h81, 1'b0);
        hold(1'b0, 5 * BIT);
        chk("break_ferr", fe_cnt - f0, 1);
        chk("break_busy", busy, 1);
        chk("break_rises", rise_cnt - r0, 0);
        hold(1'b1, BIT);
        chk("break_exit_busy", busy, 0);
        q0 = acc_q.size();
        send_byte(8'h42, 1'b1);
        idle(BIT / 2);
        chk("break_next_byte", qat(q0), 32'h42);
        chk("break_ferr_total", fe_cnt - f0, 1);

        // Overrun: second good frame while the first is still unconsumed.
        rx_ready = 1'b0;
        o0 = ov_cnt;
        send_byte(8'h11, 1'b1);
        chk("ovr_none_yet", ov_cnt - o0, 0);
        send_byte(8'h22, 1'b1);
        idle(BIT / 2);
        chk("ovr_valid", rx_valid, 1);
        chk("ovr_data_kept", rx_data, 32'h11);
        chk("ovr_pulses", ov_cnt - o0, 1);
        rx_ready = 1'b1;
        idle(1);
        rx_ready = 1'b0;
        chk("ovr_accept_valid", rx_valid, 0);

        // Reset asserted during bit 4 of a frame aborts it at once.
        f0 = fe_cnt;
        r0 = rise_cnt;
        part = 8'hC3;
        hold(1'b0, BIT);
        for (int i = 0; i < 4; i++) hold(part[i], BIT);
        hold(part[4], BIT / 2);
        chk("midframe_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("midrst_data", rx_data, 0);
        chk("midrst_valid", rx_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ferr", frame_err, 0);
        idle(3);
        rx = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(BIT);
        send_byte(8'hC3, 1'b1);
        idle(BIT / 2);
        chk("post_rst_valid", rx_valid, 1);
        chk("post_rst_data", rx_data, 32'hC3);
        chk("post_rst_rises", rise_cnt - r0, 1);
        chk("post_rst_ferr", fe_cnt - f0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
